// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and MEM accesses onto one variable-latency req/ack memory
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              stall_mem,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack
);
  typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_MEM, RESP_IF, RESP_MEM} state_t;
  state_t     state;
  logic [3:0] streak;
  logic       discard;
  logic       mem_any;
  logic       grant_mem;
  assign mem_any   = mem_rd | mem_wr;
  assign grant_mem = mem_any & ~(if_req & (streak == 4'(MEM_STREAK_MAX)));
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = mem_any & ~mem_valid;
  // Arbitration FSM: grant in IDLE, hold the request until ack, one response cycle before re-arbitrating
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      streak    <= '0;
      discard   <= 1'b0;
    end else begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      case (state)
        IDLE:
          if (grant_mem) begin
            state     <= BUSY_MEM;
            ram_req   <= 1'b1;
            ram_we    <= mem_wr;
            ram_addr  <= mem_addr;
            ram_wdata <= mem_wdata;
            streak    <= if_req ? streak + 4'd1 : 4'd0;
          end else if (if_req) begin
            state     <= BUSY_IF;
            ram_req   <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= if_addr;
            ram_wdata <= mem_wdata;
            streak    <= '0;
          end
        BUSY_IF: begin
          discard <= discard | if_flush;
          if (ram_ack) begin
            ram_req  <= 1'b0;
            if_rdata <= ram_rdata;
            if_valid <= ~(discard | if_flush);
            state    <= RESP_IF;
          end
        end
        BUSY_MEM:
          if (ram_ack) begin
            ram_req   <= 1'b0;
            mem_rdata <= ram_we ? mem_rdata : ram_rdata;
            mem_valid <= 1'b1;
            state     <= RESP_MEM;
          end
        RESP_IF, RESP_MEM: begin
          discard <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a latency-programmable memory responder
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 1;
  logic        if_req = 0, if_flush = 0, mem_rd = 0, mem_wr = 0;
  logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_valid, stall_if, mem_valid, stall_mem, ram_req, ram_we, ram_ack;
  int          passed = 0, total = 0;
  int          lat = 1, n;
  logic        resp_en = 1, force_ack = 0;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} ram_t;
  ram_t        ram_q[$];
  logic [31:0] if_q[$], mem_q[$];
  ram_t        cur;
  logic        have_cur = 0, prev_req = 0;
  int          ncyc = 0, last_cycles = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_STREAK_MAX(2)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_rdata(if_rdata),
    .if_valid(if_valid), .stall_if(stall_if),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .stall_mem(stall_mem),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    total++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h8C08_0004;
      32'h100: return 32'h1234_5678;
      32'h300: return 32'hCAFE_0300;
      32'h80:  return 32'h2008_0080;
      default: return a ^ 32'h5A5A_5A5A;
    endcase
  endfunction

  function automatic logic sig_of(input int w);
    return w == 0 ? ram_req : w == 1 ? if_valid : mem_valid;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input int w, input string name);
    int k = 0;
    do begin step(); k++; end while (!sig_of(w) && k < 60);
    chk(name, 32'(sig_of(w)), 32'd1);
  endtask

  task automatic push_ram(input logic we, input logic [31:0] a, input logic [31:0] d);
    ram_t e;
    e.we = we; e.addr = a; e.wdata = d;
    ram_q.push_back(e);
  endtask

  // Memory responder: ack lat cycles after ram_req first rises, data looked up by address
  initial begin
    int c = 0;
    logic busy = 0;
    ram_ack = 0;
    ram_rdata = 0;
    forever begin
      step();
      ram_ack = force_ack;
      if (resp_en && ram_req) begin
        if (!busy) begin busy = 1; c = 0; end
        else c++;
        if (c == lat) begin
          ram_ack = 1;
          ram_rdata = rdata_of(ram_addr);
          busy = 0;
        end
      end else busy = 0;
    end
  end

  // Monitor: pops expected requests and responses whenever the DUT presents them
  always @(negedge clk) if (!reset) begin
    if (ram_req && !prev_req) begin
      if (ram_q.size() == 0) begin fail("ram_unexpected_req", ram_addr); have_cur = 0; end
      else begin cur = ram_q.pop_front(); have_cur = 1; end
      ncyc = 0;
    end
    if (ram_req) begin
      ncyc++;
      if (have_cur) begin
        chk("ram_addr", ram_addr, cur.addr);
        chk("ram_we", 32'(ram_we), 32'(cur.we));
        if (cur.we) chk("ram_wdata", ram_wdata, cur.wdata);
      end
    end
    if (!ram_req && prev_req) last_cycles = ncyc;
    prev_req = ram_req;
    if (if_valid) begin
      if (if_q.size() == 0) fail("if_valid_unexpected", if_rdata);
      else chk("if_rdata", if_rdata, if_q.pop_front());
    end
    if (mem_valid) begin
      if (mem_q.size() == 0) fail("mem_valid_unexpected", mem_rdata);
      else chk("mem_rdata", mem_rdata, mem_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    reset = 0;
    step();
    chk("rst_ram_req", 32'(ram_req), 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_valids", {30'd0, if_valid, mem_valid}, 0);

    // 1: IF only, ack one cycle after ram_req
    lat = 1;
    push_ram(0, 32'h40, 0);
    if_q.push_back(32'h8C08_0004);
    if_req = 1; if_addr = 32'h40;
    step();
    chk("t1_req_c1", 32'(ram_req), 1);
    chk("t1_stall_c1", 32'(stall_if), 1);
    step();
    chk("t1_stall_c2", 32'(stall_if), 1);
    chk("t1_valid_c2", 32'(if_valid), 0);
    step();
    chk("t1_valid_c3", 32'(if_valid), 1);
    chk("t1_stall_c3", 32'(stall_if), 0);
    if_req = 0;
    repeat (3) step();
    chk("t1_req_cycles", 32'(last_cycles), 2);

    // 2: simultaneous requests, MEM first, IF stalled throughout
    push_ram(0, 32'h100, 0);
    push_ram(0, 32'h40, 0);
    mem_q.push_back(32'h1234_5678);
    if_q.push_back(32'h8C08_0004);
    if_req = 1; if_addr = 32'h40; mem_rd = 1; mem_addr = 32'h100;
    step();
    n = 0;
    while (!mem_valid && n < 60) begin
      chk("t2_stall_if_busy", 32'(stall_if), 1);
      step();
      n++;
    end
    chk("t2_mem_valid", 32'(mem_valid), 1);
    chk("t2_stall_if_resp", 32'(stall_if), 1);
    chk("t2_stall_mem_resp", 32'(stall_mem), 0);
    mem_rd = 0;
    wait_sig(1, "t2_if_valid");
    if_req = 0;
    repeat (3) step();

    // 3: store with ack latency 3, mem_rdata keeps the last load value
    lat = 3;
    push_ram(1, 32'h200, 32'hDEAD_BEEF);
    mem_q.push_back(32'h1234_5678);
    mem_wr = 1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF;
    wait_sig(2, "t3_mem_valid");
    chk("t3_stall_mem_valid", 32'(stall_mem), 0);
    mem_wr = 0; mem_wdata = 0;
    repeat (3) step();
    chk("t3_req_cycles", 32'(last_cycles), 4);

    // 4: fairness with streak limit 2: MEM, MEM, IF, MEM
    lat = 0;
    push_ram(0, 32'h300, 0);
    push_ram(0, 32'h300, 0);
    push_ram(0, 32'h80, 0);
    push_ram(0, 32'h300, 0);
    repeat (3) mem_q.push_back(32'hCAFE_0300);
    if_q.push_back(32'h2008_0080);
    if_req = 1; if_addr = 32'h80; mem_rd = 1; mem_addr = 32'h300;
    n = 0;
    for (int k = 0; k < 100 && n < 3; k++) begin
      step();
      if (mem_valid) n++;
    end
    chk("t4_mem_done", 32'(n), 3);
    if_req = 0; mem_rd = 0;
    repeat (3) step();

    // 5: flush during BUSY_IF discards the fetch; redirected address delivered
    lat = 2;
    push_ram(0, 32'h40, 0);
    push_ram(0, 32'h80, 0);
    if_q.push_back(32'h2008_0080);
    if_req = 1; if_addr = 32'h40;
    wait_sig(0, "t5_req");
    if_flush = 1; if_addr = 32'h80;
    step();
    if_flush = 0;
    wait_sig(1, "t5_if_valid");
    if_req = 0;
    repeat (3) step();

    // 6: asynchronous reset mid BUSY_MEM, later stray ack ignored
    resp_en = 0;
    push_ram(0, 32'h500, 0);
    mem_rd = 1; mem_addr = 32'h500;
    wait_sig(0, "t6_req");
    step();
    #2 reset = 1;
    #1;
    chk("t6_ram_req", 32'(ram_req), 0);
    chk("t6_ram_addr", ram_addr, 0);
    chk("t6_mem_rdata", mem_rdata, 0);
    chk("t6_if_rdata", if_rdata, 0);
    mem_rd = 0;
    step();
    reset = 0;
    #2 force_ack = 1;
    step();
    #2 force_ack = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_no_mem_valid", 32'(mem_valid), 0);
      chk("t6_no_req", 32'(ram_req), 0);
    end

    chk("ram_q_left", ram_q.size(), 0);
    chk("if_q_left", if_q.size(), 0);
    chk("mem_q_left", mem_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
